// File: rtl/alu_seq_n.sv
// Registered, handshaked N-bit ALU with a persistent carry flag, shifts and an
// iterative shift-add multiplier. Single-cycle ops load the output register on
// the accept edge; MUL/MULH spend NBits cycles in BUSY producing one partial
// product per cycle into a 2*NBits accumulator.
module alu_seq_n #(
    parameter int NBits   = 8,
    parameter int SHAMT_W = $clog2(NBits)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       selection,
    input  logic [NBits-1:0] A,
    input  logic [NBits-1:0] B,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBits-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry_out,
    output logic             overflow,
    output logic             cflag,
    output logic             op_err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADC  = 4'd6;
    localparam logic [3:0] OP_SBC  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_MULH = 4'd12;
    localparam logic [3:0] OP_CMP  = 4'd13;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(NBits - 1);
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;

    // Shift amount reduced modulo NBits (only matters when NBits is not a power of two).
    function automatic logic [SHAMT_W-1:0] shamt_mod(input logic [SHAMT_W-1:0] raw);
        if (int'(raw) >= NBits) return SHAMT_W'(int'(raw) - NBits);
        return raw;
    endfunction

    logic                     accept;
    logic                     is_mul_sel;
    logic [SHAMT_W-1:0]       sh;
    logic                     add_cin;
    logic                     sub_bor;
    logic [NBits:0]           sum_w;
    logic [NBits:0]           dif_w;
    logic [NBits:0]           shl_w;
    logic [NBits:0]           shr_w;
    logic signed [NBits:0]    asr_ext;
    logic signed [NBits:0]    asr_w;

    logic [NBits-1:0]         op_res;
    logic [NBits-1:0]         op_fres;
    logic                     op_c;
    logic                     op_v;
    logic                     op_e;
    logic                     op_cf_upd;

    logic [SHAMT_W-1:0]       mul_cnt;
    logic [2*NBits-1:0]       mul_acc;
    logic [2*NBits-1:0]       mul_mcand;
    logic [NBits-1:0]         mul_mplier;
    logic                     mul_hi_q;
    logic [2*NBits-1:0]       mul_add;
    logic [2*NBits-1:0]       mul_acc_nxt;
    logic                     mul_done;

    logic                     ld_en;
    logic [NBits-1:0]         ld_res;
    logic [NBits-1:0]         ld_fres;
    logic                     ld_c;
    logic                     ld_v;
    logic                     ld_e;
    logic                     ld_cf_upd;

    assign in_ready   = (state_q == IDLE) & (~out_valid | out_ready);
    assign accept     = in_valid & in_ready;
    assign is_mul_sel = (selection == OP_MUL) | (selection == OP_MULH);

    assign sh      = shamt_mod(B[SHAMT_W-1:0]);
    assign add_cin = (selection == OP_ADC) ? cflag : carry_in;
    assign sub_bor = (selection == OP_SBC) ? ~cflag : 1'b0;
    assign sum_w   = {1'b0, A} + {1'b0, B} + {{NBits{1'b0}}, add_cin};
    assign dif_w   = {1'b0, A} - {1'b0, B} - {{NBits{1'b0}}, sub_bor};
    // Guard bit above (left shift) or below (right shifts) catches the last bit shifted out.
    assign shl_w   = {1'b0, A} << sh;
    assign shr_w   = {A, 1'b0} >> sh;
    assign asr_ext = {A, 1'b0};
    assign asr_w   = asr_ext >>> sh;

    assign mul_add     = mul_mplier[0] ? mul_mcand : '0;
    assign mul_acc_nxt = mul_acc + mul_add;
    assign mul_done    = (state_q == BUSY) && (mul_cnt == CNT_LAST);

    // Single-cycle operation result and flags, decoded from the live request.
    always_comb begin
        op_res    = '0;
        op_c      = 1'b0;
        op_v      = 1'b0;
        op_e      = 1'b0;
        op_cf_upd = 1'b0;
        case (selection)
            OP_ADD, OP_ADC: begin
                op_res    = sum_w[NBits-1:0];
                op_c      = sum_w[NBits];
                op_v      = (A[NBits-1] == B[NBits-1]) && (sum_w[NBits-1] != A[NBits-1]);
                op_cf_upd = 1'b1;
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                op_res    = (selection == OP_CMP) ? A : dif_w[NBits-1:0];
                op_c      = ~dif_w[NBits];
                op_v      = (A[NBits-1] != B[NBits-1]) && (dif_w[NBits-1] != A[NBits-1]);
                op_cf_upd = 1'b1;
            end
            OP_AND: op_res = A & B;
            OP_OR:  op_res = A | B;
            OP_NOT: op_res = ~A;
            OP_XOR: op_res = A ^ B;
            OP_SHL: begin
                op_res    = shl_w[NBits-1:0];
                op_c      = shl_w[NBits];
                op_cf_upd = 1'b1;
            end
            OP_SHR: begin
                op_res    = shr_w[NBits:1];
                op_c      = shr_w[0];
                op_cf_upd = 1'b1;
            end
            OP_ASR: begin
                op_res    = asr_w[NBits:1];
                op_c      = asr_w[0];
                op_cf_upd = 1'b1;
            end
            OP_MUL, OP_MULH: op_res = '0;
            default: op_e = 1'b1;
        endcase
        // CMP reports the difference's Z/N while passing A through as the result.
        op_fres = (selection == OP_CMP) ? dif_w[NBits-1:0] : op_res;
    end

    // Select what loads the output register: a finishing multiply or an accepted 1-cycle op.
    always_comb begin
        ld_en     = 1'b0;
        ld_res    = '0;
        ld_fres   = '0;
        ld_c      = 1'b0;
        ld_v      = 1'b0;
        ld_e      = 1'b0;
        ld_cf_upd = 1'b0;
        if (mul_done) begin
            ld_en = 1'b1;
            if (mul_hi_q) begin
                ld_res = mul_acc_nxt[2*NBits-1:NBits];
            end else begin
                ld_res = mul_acc_nxt[NBits-1:0];
                ld_c   = |mul_acc_nxt[2*NBits-1:NBits];
                ld_v   = |mul_acc_nxt[2*NBits-1:NBits];
            end
            ld_fres = ld_res;
        end else if (accept && !is_mul_sel) begin
            ld_en     = 1'b1;
            ld_res    = op_res;
            ld_fres   = op_fres;
            ld_c      = op_c;
            ld_v      = op_v;
            ld_e      = op_e;
            ld_cf_upd = op_cf_upd;
        end
    end

    // Next-state logic: multiplies park in BUSY for NBits iterations.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && is_mul_sel) state_d = BUSY;
            BUSY: if (mul_cnt == CNT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and iteration counter; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mul_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) mul_cnt <= '0;
            else                 mul_cnt <= mul_cnt + CNT_ONE;
        end
    end

    // Shift-add multiplier datapath: one partial product per BUSY cycle.
    always_ff @(posedge clk) begin
        if (accept && is_mul_sel) begin
            mul_acc    <= '0;
            mul_mcand  <= {{NBits{1'b0}}, A};
            mul_mplier <= B;
            mul_hi_q   <= (selection == OP_MULH);
        end else if (state_q == BUSY) begin
            mul_acc    <= mul_acc_nxt;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
        end
    end

    // Output register: holds under back-pressure, reloads or drains on handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            op_err    <= 1'b0;
            cflag     <= 1'b0;
        end else if (ld_en) begin
            out_valid <= 1'b1;
            result    <= ld_res;
            zero      <= ~|ld_fres;
            negative  <= ld_fres[NBits-1];
            carry_out <= ld_c;
            overflow  <= ld_v;
            op_err    <= ld_e;
            if (ld_cf_upd) cflag <= ld_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_n.sv
// Directed bench for alu_seq_n (NBits=8) with hand-computed expectations.
module tb_alu_seq_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] selection = 4'd0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       carry_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       zero, negative, carry_out, overflow, cflag, op_err;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_n #(.NBits(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .selection(selection), .A(A), .B(B), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
        .cflag(cflag), .op_err(op_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
        int t = 0;
        selection = op; A = a; B = b; carry_in = ci; in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        if (!in_ready) chk("issue_rdy", {31'b0, in_ready}, 1);
        step();
        in_valid = 1'b0;
    endtask

    // fl = {zero, negative, carry_out, overflow, op_err}
    task automatic collect(input string tag, input logic [7:0] r, input logic [4:0] fl, input logic cf);
        chk({tag, "_vld"}, {31'b0, out_valid}, 1);
        chk({tag, "_res"}, {24'b0, result}, {24'b0, r});
        chk({tag, "_flg"}, {27'b0, zero, negative, carry_out, overflow, op_err}, {27'b0, fl});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_cf"}, {31'b0, cflag}, {31'b0, cf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  busy;
        bit  rdy_seen;
        bit  vld_seen;

        step(); step();
        chk("rst_vld", {31'b0, out_valid}, 0);
        chk("rst_res", {24'b0, result}, 0);
        chk("rst_flg", {26'b0, zero, negative, carry_out, overflow, op_err, cflag}, 0);
        chk("rst_rdy", {31'b0, in_ready}, 1);
        rst_n = 1'b1;
        step();

        issue(4'd0, 8'hFF, 8'h01, 1'b0); collect("add",   8'h00, 5'b10100, 1'b1);
        issue(4'd6, 8'h00, 8'h00, 1'b0); collect("adc",   8'h01, 5'b00000, 1'b0);
        issue(4'd1, 8'h80, 8'h01, 1'b0); collect("sub",   8'h7F, 5'b00110, 1'b1);
        issue(4'd7, 8'h05, 8'h03, 1'b0); collect("sbc1",  8'h02, 5'b00100, 1'b1);
        issue(4'd2, 8'hF0, 8'h3C, 1'b0); collect("and",   8'h30, 5'b00000, 1'b1);
        issue(4'd3, 8'hF0, 8'h0F, 1'b0); collect("or",    8'hFF, 5'b01000, 1'b1);
        issue(4'd4, 8'h0F, 8'h00, 1'b0); collect("not",   8'hF0, 5'b01000, 1'b1);
        issue(4'd5, 8'hAA, 8'hAA, 1'b0); collect("xor",   8'h00, 5'b10000, 1'b1);
        issue(4'd13, 8'h01, 8'h02, 1'b0); collect("cmp",  8'h01, 5'b01000, 1'b0);
        issue(4'd7, 8'h05, 8'h03, 1'b0); collect("sbc0",  8'h01, 5'b00100, 1'b1);
        issue(4'd0, 8'h7F, 8'h00, 1'b1); collect("addci", 8'h80, 5'b01010, 1'b0);

        issue(4'd11, 8'd20, 8'd13, 1'b0);
        busy = 0; rdy_seen = 1'b0;
        while (!out_valid && busy < 20) begin
            if (in_ready) rdy_seen = 1'b1;
            step();
            busy++;
        end
        chk("mul_busy", busy, 8);
        chk("mul_rdy_low", {31'b0, rdy_seen}, 0);
        collect("mul", 8'h04, 5'b00110, 1'b0);

        issue(4'd12, 8'd20, 8'd13, 1'b0);
        busy = 0;
        while (!out_valid && busy < 20) begin
            step();
            busy++;
        end
        chk("mulh_busy", busy, 8);
        collect("mulh", 8'h01, 5'b00000, 1'b0);

        issue(4'd10, 8'h90, 8'd3, 1'b0); collect("asr",   8'hF2, 5'b01000, 1'b0);
        issue(4'd8,  8'h81, 8'd1, 1'b0); collect("shl",   8'h02, 5'b00100, 1'b1);
        issue(4'd9,  8'h81, 8'd8, 1'b0); collect("shr8",  8'h81, 5'b01000, 1'b0);
        issue(4'd9,  8'h81, 8'd1, 1'b0); collect("shr1",  8'h40, 5'b00100, 1'b1);
        issue(4'd10, 8'h81, 8'd9, 1'b0); collect("asr9",  8'hC0, 5'b01100, 1'b1);

        // Back-pressure: result must hold while the consumer stalls.
        issue(4'd5, 8'h0F, 8'h01, 1'b0);
        selection = 4'd3; A = 8'h01; B = 8'h02; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rdy", {31'b0, in_ready}, 0);
            chk("bp_hold", {23'b0, out_valid, result}, {23'b0, 1'b1, 8'h0E});
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_xfer1", {23'b0, out_valid, result}, {23'b0, 1'b1, 8'h03});
        selection = 4'd0; A = 8'h01; B = 8'h01; carry_in = 1'b0;
        step();
        chk("bp_xfer2", {23'b0, out_valid, result}, {23'b0, 1'b1, 8'h02});
        in_valid = 1'b0;
        step();
        chk("bp_drain", {31'b0, out_valid}, 0);
        out_ready = 1'b0;

        // Reset in the middle of a multiply.
        issue(4'd8, 8'h81, 8'd1, 1'b0); collect("shl2", 8'h02, 5'b00100, 1'b1);
        out_ready = 1'b1;
        issue(4'd11, 8'd20, 8'd13, 1'b0);
        step(); step(); step();
        rst_n = 1'b0;
        step();
        chk("mrst_vld", {31'b0, out_valid}, 0);
        chk("mrst_res", {24'b0, result}, 0);
        chk("mrst_flg", {26'b0, zero, negative, carry_out, overflow, op_err, cflag}, 0);
        chk("mrst_rdy", {31'b0, in_ready}, 1);
        rst_n = 1'b1;
        vld_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) vld_seen = 1'b1;
        end
        chk("mrst_noout", {31'b0, vld_seen}, 0);
        out_ready = 1'b0;

        issue(4'd8,  8'h81, 8'd1, 1'b0); collect("shl3", 8'h02, 5'b00100, 1'b1);
        issue(4'd14, 8'hAA, 8'h55, 1'b0); collect("rsv14", 8'h00, 5'b10001, 1'b1);
        issue(4'd15, 8'hFF, 8'hFF, 1'b1); collect("rsv15", 8'h00, 5'b10001, 1'b1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
